// File: rtl/regfile_init.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_init : 2-read/1-write register file, r0 = 0, RAM storage that is |
// |   cleared by a post-reset sweep which stalls the pipeline until done.    |
// | Optional same-cycle write-to-read bypass: define REGFILE_WR_BYPASS_EN.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module regfile_init #(
  parameter int                NUM_REGS  = 32,
  parameter int                ADDR_W    = 5,
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] CLR_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic              stallreq
);

  localparam logic [0:0]        C_ST_CLEAR  = 1'b0;
  localparam logic [0:0]        C_ST_RUN    = 1'b1;
  localparam logic [ADDR_W-1:0] C_CNT_LAST  = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W:0]   C_ADDR_LAST = (ADDR_W + 1)'(NUM_REGS - 1);

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

  logic [DATA_W-1:0] mem [NUM_REGS];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic              running;

  // Addresses beyond the implemented depth read as zero and are never written.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} <= C_ADDR_LAST);
  endfunction

  assign running  = !rst && (state_q == C_ST_RUN);
  assign stallreq = !running;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    mem_we    = 1'b0;
    mem_waddr = clr_cnt_q;
    mem_wdata = CLR_VALUE;
    if (!rst) begin
      if (state_q == C_ST_CLEAR) begin
        mem_we = 1'b1;
        // The counter parks on the last entry; only rst returns it to zero.
        if (clr_cnt_q == C_CNT_LAST) begin
          state_d = C_ST_RUN;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end else if (we && (waddr != '0) && in_range(waddr)) begin
        mem_we    = 1'b1;
        mem_waddr = waddr;
        mem_wdata = wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= C_ST_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  logic [1:0]             rd_en;
  logic [1:0][ADDR_W-1:0] rd_addr;
  logic [1:0]             rd_hit;
  logic [1:0]             rd_byp;
  logic [1:0][DATA_W-1:0] rd_data;

  assign rd_en   = {re2, re1};
  assign rd_addr = {raddr2, raddr1};

  for (genvar p = 0; p < 2; p++) begin : g_rd_port
    assign rd_hit[p] = running && rd_en[p] && (rd_addr[p] != '0) && in_range(rd_addr[p]);
`ifdef REGFILE_WR_BYPASS_EN
    assign rd_byp[p] = we && (waddr == rd_addr[p]);
`else
    assign rd_byp[p] = 1'b0;
`endif
    assign rd_data[p] = !rd_hit[p] ? '0 :
                        rd_byp[p]  ? wdata : mem[rd_addr[p]];
  end

  assign rdata1 = rd_data[0];
  assign rdata2 = rd_data[1];

endmodule
`default_nettype wire

// File: tb/tb_regfile_init.sv
`default_nettype none
// tb_regfile_init : directed + random stimulus against a reference model of
// the register file (array contents plus remaining stall cycles).
module tb_regfile_init;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              re1;
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] rdata1;
  logic              re2;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata2;
  logic              stallreq;

  always #5 clk = ~clk;

  regfile_init #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .CLR_VALUE('0)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .re1     (re1),
    .raddr1  (raddr1),
    .rdata1  (rdata1),
    .re2     (re2),
    .raddr2  (raddr2),
    .rdata2  (rdata2),
    .stallreq(stallreq)
  );

  logic [DATA_W-1:0] model_mem [NUM_REGS];
  int                stall_left = NUM_REGS;
  int                checks = 0;
  int                errors = 0;
  logic              last_stall;

  function automatic logic [DATA_W-1:0] exp_rd(input logic en, input logic [ADDR_W-1:0] a);
    if (rst || stall_left > 0) return '0;
    if (!en) return '0;
    if (a == '0) return '0;
`ifdef REGFILE_WR_BYPASS_EN
    if (we && waddr == a) return wdata;
`endif
    return model_mem[a];
  endfunction

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: compare outputs mid-cycle, then advance the model on the edge.
  task automatic cycle();
    @(negedge clk);
    last_stall = stallreq;
    chk("stallreq", {31'b0, stallreq}, {31'b0, (rst || stall_left > 0)});
    chk("rdata1", rdata1, exp_rd(re1, raddr1));
    chk("rdata2", rdata2, exp_rd(re2, raddr2));
    @(posedge clk);
    if (rst) begin
      stall_left = NUM_REGS;
    end else if (stall_left > 0) begin
      stall_left--;
      if (stall_left == 0) begin
        foreach (model_mem[i]) model_mem[i] = '0;
      end
    end else if (we && waddr != '0) begin
      model_mem[waddr] = wdata;
    end
    #1;
  endtask

  // Counts stalled cycles until stallreq drops; write enable is released at RUN.
  task automatic count_stall(output int n);
    n = 0;
    for (int k = 0; k < 64; k++) begin
      cycle();
      if (!last_stall) break;
      n++;
      if (stall_left == 0) we = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
    re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b0; raddr2 = '0;
    cycle();

    // Sweep after reset, with a write to r7 held throughout and reads of r5/r7.
    rst = 1'b0; we = 1'b1; waddr = 5'd7; wdata = 32'h55;
    re2 = 1'b1; raddr2 = 5'd7;
    count_stall(n);
    chk("sweep_len", n, 32);
    chk("r7_after_sweep", rdata2, 32'h0);
    for (int a = 1; a < NUM_REGS; a++) begin
      raddr1 = a[ADDR_W-1:0]; raddr2 = 5'(NUM_REGS - a);
      cycle();
    end

    // Write r3 with a same-cycle read, then the following-cycle read.
    we = 1'b1; waddr = 5'd3; wdata = 32'hDEADBEEF;
    re1 = 1'b1; raddr1 = 5'd3; re2 = 1'b1; raddr2 = 5'd3;
    cycle();
    we = 1'b0;
    cycle();
    chk("r3_next", rdata1, 32'hDEADBEEF);

    // Writes to r0 are discarded and r0 always reads zero.
    we = 1'b1; waddr = 5'd0; wdata = 32'h00001234;
    raddr1 = 5'd0; raddr2 = 5'd0;
    cycle();
    we = 1'b0;
    cycle();
    chk("r0_read", rdata2, 32'h0);

    // Per-port read enable.
    we = 1'b1; waddr = 5'd4; wdata = 32'hA5A5A5A5; re1 = 1'b0; re2 = 1'b0;
    cycle();
    we = 1'b0; re1 = 1'b0; raddr1 = 5'd4; re2 = 1'b1; raddr2 = 5'd4;
    cycle();
    chk("r4_re1_off", rdata1, 32'h0);
    chk("r4_re2_on", rdata2, 32'hA5A5A5A5);

    // Random traffic with occasional resets.
    for (int k = 0; k < 400; k++) begin
      rst    = ($urandom_range(0, 99) == 0);
      we     = 1'($urandom_range(0, 1));
      waddr  = 5'($urandom_range(0, NUM_REGS - 1));
      wdata  = $urandom;
      re1    = ($urandom_range(0, 3) != 0);
      re2    = ($urandom_range(0, 3) != 0);
      raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, NUM_REGS - 1));
      raddr2 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, NUM_REGS - 1));
      cycle();
    end

    // Make sure RUN, then fill every register with non-zero data.
    rst = 1'b0; we = 1'b0;
    count_stall(n);
    for (int a = 1; a < NUM_REGS; a++) begin
      we = 1'b1; waddr = a[ADDR_W-1:0]; wdata = $urandom | 32'h1;
      re1 = 1'b1; raddr1 = waddr; re2 = 1'b1; raddr2 = 5'(a - 1);
      cycle();
    end
    we = 1'b0;

    // Reset re-asserted mid-sweep restarts a full sweep.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    repeat (10) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    count_stall(n);
    chk("resweep_len", n, 32);
    re1 = 1'b1; re2 = 1'b1;
    for (int a = 1; a < NUM_REGS; a++) begin
      raddr1 = a[ADDR_W-1:0]; raddr2 = 5'(NUM_REGS - a);
      cycle();
      chk("cleared", rdata1, 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
